// File: rtl/rca_seq_adder.sv
// rca_seq_adder: multi-cycle WIDTH-bit adder built around one 3-bit ripple-carry slice.
// Operands are captured through a valid/ready handshake. The slice then steps from LSB to MSB,
// one slice per clock, with the inter-slice carry held in a register. The result is presented
// through a valid/ready handshake.
//
// Optional feature: define RCA_SEQ_BTB_EN for back-to-back accept. New operands may then be
// captured in the same cycle that the DONE result retires.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   in_valid  in   a/b/cin valid
//   in_ready  out  operands can be accepted this cycle
//   a, b      in   WIDTH-bit unsigned operands
//   cin       in   carry into slice 0
//   out_valid out  sum/cout hold a completed result
//   out_ready in   consumer takes the result this cycle
//   sum       out  a+b+cin modulo 2^WIDTH (registered)
//   cout      out  carry out of the MSB slice (registered)
//   busy      out  high while slices are being stepped
module rca_seq_adder #(
  parameter int unsigned NSLICES = 4,
  localparam int unsigned WIDTH  = 3 * NSLICES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int unsigned IdxW = (NSLICES > 1) ? $clog2(NSLICES) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              carry_q, carry_d;
  logic [IdxW-1:0]   idx_q, idx_d;

  logic [2:0]        slice_a, slice_b;
  logic [3:0]        slice_res;
  logic              accept;

  // Select the active 3-bit operand slice; a constant-index loop keeps the mux width-clean.
  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int unsigned i = 0; i < NSLICES; i++) begin
      if (idx_q == IdxW'(i)) begin
        slice_a = a_q[3*i +: 3];
        slice_b = b_q[3*i +: 3];
      end
    end
    slice_res = {1'b0, slice_a} + {1'b0, slice_b} + {3'b000, carry_q};
  end

`ifdef RCA_SEQ_BTB_EN
  assign in_ready = (state_q == StIdle) || ((state_q == StDone) && out_ready);
`else
  assign in_ready = (state_q == StIdle);
`endif

  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q == StRun);
  assign sum       = sum_q;
  assign cout      = carry_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    idx_d   = idx_q;

    unique case (state_q)
      StIdle: begin
      end
      StRun: begin
        for (int unsigned i = 0; i < NSLICES; i++) begin
          if (idx_q == IdxW'(i)) begin
            sum_d[3*i +: 3] = slice_res[2:0];
          end
        end
        carry_d = slice_res[3];
        if (idx_q == IdxW'(NSLICES - 1)) begin
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Capture wins over the DONE->IDLE return, which gives the back-to-back path when enabled.
    if (accept) begin
      a_d     = a;
      b_d     = b;
      carry_d = cin;
      idx_d   = '0;
      sum_d   = '0;
      state_d = StRun;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
    end
  end

endmodule
